// File: rtl/divider_pkg.sv
// Shared definitions for the execute-stage divider: bus widths, handshake levels,
// FSM state encodings and two's-complement helpers.
package divider_pkg;

    localparam int REG_BUS    = 32;
    localparam int DOUBLE_BUS = 64;

    localparam logic RST_ENABLE = 1'b1;
    localparam logic [REG_BUS-1:0] ZERO_WORD = 32'h0000_0000;

    localparam logic DIV_START            = 1'b1;
    localparam logic DIV_STOP             = 1'b0;
    localparam logic DIV_RESULT_READY     = 1'b1;
    localparam logic DIV_RESULT_NOT_READY = 1'b0;

    localparam logic [5:0] DIV_ITERS = 6'd32;

    typedef enum logic [1:0] {
        DIV_FREE    = 2'b00,
        DIV_BY_ZERO = 2'b01,
        DIV_ON      = 2'b10,
        DIV_END     = 2'b11
    } div_state_e;

    function automatic logic [REG_BUS-1:0] twos_negate(input logic [REG_BUS-1:0] value);
        return ~value + 32'd1;
    endfunction

    // Absolute value only when the operand is interpreted as signed.
    function automatic logic [REG_BUS-1:0] magnitude(input logic [REG_BUS-1:0] value,
                                                     input logic               is_signed);
        logic [REG_BUS-1:0] mag;
        if (is_signed && value[REG_BUS-1]) begin
            mag = twos_negate(value);
        end else begin
            mag = value;
        end
        return mag;
    endfunction

endpackage

// File: rtl/divider.sv
// Multi-cycle 32-bit restoring divider for DIV/DIVU; result_o = {remainder, quotient}.
// Optional macro DIV_ZERO_DETECT_EN enables the two-cycle divide-by-zero short path.
module divider
    import divider_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  signed_div_i,
    input  logic [REG_BUS-1:0]    opdata1_i,
    input  logic [REG_BUS-1:0]    opdata2_i,
    input  logic                  start_i,
    input  logic                  annul_i,
    output logic [DOUBLE_BUS-1:0] result_o,
    output logic                  ready_o
);

    div_state_e            state_r,          state_nxt_s;
    logic [5:0]            cnt_r,            cnt_nxt_s;
    logic [64:0]           work_r,           work_nxt_s;
    logic [REG_BUS-1:0]    divisor_r,        divisor_nxt_s;
    logic                  neg_dividend_r,   neg_dividend_nxt_s;
    logic                  neg_divisor_r,    neg_divisor_nxt_s;
    logic [DOUBLE_BUS-1:0] result_nxt_s;
    logic                  ready_nxt_s;

    logic [32:0]           cand_s;
    logic                  ge_s;
    logic [REG_BUS-1:0]    diff_s;
    logic [64:0]           step_s;
    logic [REG_BUS-1:0]    quot_fix_s;
    logic [REG_BUS-1:0]    rem_fix_s;

    // One restoring iteration; the partial remainder candidate keeps its 33rd bit so
    // divisors above 2^31 compare correctly.
    always_comb begin
        cand_s = work_r[64:32];
        ge_s   = (cand_s >= {1'b0, divisor_r});
        diff_s = cand_s[31:0] - divisor_r;
        if (ge_s) begin
            step_s = {diff_s, work_r[31:0], 1'b1};
        end else begin
            step_s = {work_r[63:0], 1'b0};
        end
    end

    // Sign fix-up applied to the magnitude result once all iterations are done.
    always_comb begin
        if (neg_dividend_r ^ neg_divisor_r) begin
            quot_fix_s = twos_negate(work_r[31:0]);
        end else begin
            quot_fix_s = work_r[31:0];
        end
        if (neg_dividend_r) begin
            rem_fix_s = twos_negate(work_r[64:33]);
        end else begin
            rem_fix_s = work_r[64:33];
        end
    end

    // Next-state and next-output logic for the divider FSM.
    always_comb begin
        state_nxt_s        = state_r;
        cnt_nxt_s          = cnt_r;
        work_nxt_s         = work_r;
        divisor_nxt_s      = divisor_r;
        neg_dividend_nxt_s = neg_dividend_r;
        neg_divisor_nxt_s  = neg_divisor_r;
        result_nxt_s       = result_o;
        ready_nxt_s        = ready_o;

        case (state_r)
            DIV_FREE: begin
                if ((start_i == DIV_START) && !annul_i) begin
                    neg_dividend_nxt_s = signed_div_i & opdata1_i[REG_BUS-1];
                    neg_divisor_nxt_s  = signed_div_i & opdata2_i[REG_BUS-1];
                    divisor_nxt_s      = magnitude(opdata2_i, signed_div_i);
                    work_nxt_s         = {32'h0000_0000, magnitude(opdata1_i, signed_div_i), 1'b0};
                    cnt_nxt_s          = 6'd0;
`ifdef DIV_ZERO_DETECT_EN
                    if (opdata2_i == ZERO_WORD) begin
                        state_nxt_s = DIV_BY_ZERO;
                    end else begin
                        state_nxt_s = DIV_ON;
                    end
`else
                    state_nxt_s = DIV_ON;
`endif
                end else begin
                    state_nxt_s = DIV_FREE;
                end
            end

            DIV_BY_ZERO: begin
`ifdef DIV_ZERO_DETECT_EN
                work_nxt_s   = 65'd0;
                result_nxt_s = {ZERO_WORD, ZERO_WORD};
                ready_nxt_s  = DIV_RESULT_READY;
                state_nxt_s  = DIV_END;
`else
                // Reserved encoding without zero detection: recover to idle.
                work_nxt_s   = 65'd0;
                result_nxt_s = {ZERO_WORD, ZERO_WORD};
                ready_nxt_s  = DIV_RESULT_NOT_READY;
                state_nxt_s  = DIV_FREE;
`endif
            end

            DIV_ON: begin
                if (annul_i || (start_i == DIV_STOP)) begin
                    state_nxt_s = DIV_FREE;
                    cnt_nxt_s   = 6'd0;
                    work_nxt_s  = 65'd0;
                end else if (cnt_r < DIV_ITERS) begin
                    work_nxt_s = step_s;
                    cnt_nxt_s  = cnt_r + 6'd1;
                end else begin
                    result_nxt_s = {rem_fix_s, quot_fix_s};
                    ready_nxt_s  = DIV_RESULT_READY;
                    cnt_nxt_s    = 6'd0;
                    state_nxt_s  = DIV_END;
                end
            end

            DIV_END: begin
                // annul_i is deliberately ignored: only dropping start_i releases the result.
                if (start_i == DIV_STOP) begin
                    state_nxt_s  = DIV_FREE;
                    result_nxt_s = {ZERO_WORD, ZERO_WORD};
                    ready_nxt_s  = DIV_RESULT_NOT_READY;
                end else begin
                    state_nxt_s = DIV_END;
                end
            end

            default: begin
                state_nxt_s  = DIV_FREE;
                cnt_nxt_s    = 6'd0;
                work_nxt_s   = 65'd0;
                result_nxt_s = {ZERO_WORD, ZERO_WORD};
                ready_nxt_s  = DIV_RESULT_NOT_READY;
            end
        endcase
    end

    // State and registered-output update with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst == RST_ENABLE) begin
            state_r        <= DIV_FREE;
            cnt_r          <= 6'd0;
            work_r         <= 65'd0;
            divisor_r      <= ZERO_WORD;
            neg_dividend_r <= 1'b0;
            neg_divisor_r  <= 1'b0;
            result_o       <= {ZERO_WORD, ZERO_WORD};
            ready_o        <= DIV_RESULT_NOT_READY;
        end else begin
            state_r        <= state_nxt_s;
            cnt_r          <= cnt_nxt_s;
            work_r         <= work_nxt_s;
            divisor_r      <= divisor_nxt_s;
            neg_dividend_r <= neg_dividend_nxt_s;
            neg_divisor_r  <= neg_divisor_nxt_s;
            result_o       <= result_nxt_s;
            ready_o        <= ready_nxt_s;
        end
    end

endmodule

// File: tb/tb_divider.sv
// Self-checking bench for divider: directed cases from the test plan plus random
// operands checked against an arithmetic reference model.
module tb_divider;

    logic        clk = 1'b0;
    logic        rst;
    logic        signed_div_i;
    logic [31:0] opdata1_i;
    logic [31:0] opdata2_i;
    logic        start_i;
    logic        annul_i;
    logic [63:0] result_o;
    logic        ready_o;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    divider dut (
        .clk          (clk),
        .rst          (rst),
        .signed_div_i (signed_div_i),
        .opdata1_i    (opdata1_i),
        .opdata2_i    (opdata2_i),
        .start_i      (start_i),
        .annul_i      (annul_i),
        .result_o     (result_o),
        .ready_o      (ready_o)
    );

`ifdef DIV_ZERO_DETECT_EN
    localparam logic [63:0] EXP_U5_DIV0 = 64'h0000_0000_0000_0000;
`else
    localparam logic [63:0] EXP_U5_DIV0 = 64'h0000_0005_FFFF_FFFF;
`endif

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference {remainder, quotient} from plain integer arithmetic.
    function automatic logic [63:0] model(input logic s, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] q;
        logic [31:0] r;
        longint      sa;
        longint      sb;
        longint      lq;
        longint      lr;
        q = 32'd0;
        r = 32'd0;
        if (b == 32'd0) begin
`ifdef DIV_ZERO_DETECT_EN
            q = 32'd0;
            r = 32'd0;
`else
            // Dividing a magnitude by zero yields all-ones quotient and the magnitude as remainder.
            q = (s && a[31]) ? 32'd1 : 32'hFFFF_FFFF;
            r = a;
`endif
        end else if (!s) begin
            q = a / b;
            r = a % b;
        end else begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            lq = sa / sb;
            lr = sa % sb;
            q  = lq[31:0];
            r  = lr[31:0];
        end
        return {r, q};
    endfunction

    function automatic int exp_latency(input logic [31:0] b);
`ifdef DIV_ZERO_DETECT_EN
        return (b == 32'd0) ? 2 : 34;
`else
        return (b == 32'd0) ? 34 : 34;
`endif
    endfunction

    task automatic launch(input logic s, input logic [31:0] a, input logic [31:0] b);
        signed_div_i = s;
        opdata1_i    = a;
        opdata2_i    = b;
        start_i      = 1'b1;
    endtask

    task automatic wait_ready(output int lat);
        lat = 0;
        while (lat < 100) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            if (ready_o === 1'b1) break;
        end
    endtask

    task automatic release_op(input string tag);
        start_i = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check({tag, " release ready"}, {63'd0, ready_o}, 64'd0);
        check({tag, " release result"}, result_o, 64'd0);
    endtask

    task automatic run_check(input string tag, input logic s, input logic [31:0] a,
                             input logic [31:0] b, input logic [63:0] exp);
        int lat;
        launch(s, a, b);
        wait_ready(lat);
        check({tag, " latency"}, 64'(lat), 64'(exp_latency(b)));
        check({tag, " result"}, result_o, exp);
        release_op(tag);
    endtask

    initial begin
        int          lat;
        logic        s;
        logic [31:0] a;
        logic [31:0] b;

        rst          = 1'b1;
        start_i      = 1'b0;
        annul_i      = 1'b0;
        signed_div_i = 1'b0;
        opdata1_i    = 32'd0;
        opdata2_i    = 32'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset ready", {63'd0, ready_o}, 64'd0);
        check("reset result", result_o, 64'd0);
        rst = 1'b0;
        @(negedge clk);

        run_check("u100/7",       1'b0, 32'd100,       32'd7,        64'h0000_0002_0000_000E);
        run_check("s-7/2",        1'b1, 32'hFFFF_FFF9, 32'd2,        64'hFFFF_FFFF_FFFF_FFFD);
        run_check("uFFFFFFF9/2",  1'b0, 32'hFFFF_FFF9, 32'd2,        64'h0000_0001_7FFF_FFFC);
        run_check("s7/-2",        1'b1, 32'd7,         32'hFFFF_FFFE, 64'h0000_0001_FFFF_FFFD);
        run_check("s_overflow",   1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 64'h0000_0000_8000_0000);
        run_check("u_bigdivisor", 1'b0, 32'hFFFF_FFFF, 32'h8000_0001, 64'h7FFF_FFFE_0000_0001);
        run_check("u5/0",         1'b0, 32'd5,         32'd0,        EXP_U5_DIV0);
        run_check("s-5/0",        1'b1, 32'hFFFF_FFFB, 32'd0,        model(1'b1, 32'hFFFF_FFFB, 32'd0));

        // Result held while start_i stays high; annul_i and operand changes are ignored.
        launch(1'b0, 32'd1000, 32'd3);
        wait_ready(lat);
        check("hold latency", 64'(lat), 64'd34);
        check("hold result", result_o, 64'h0000_0001_0000_014D);
        for (int i = 0; i < 5; i++) begin
            opdata1_i = $urandom;
            opdata2_i = $urandom;
            annul_i   = (i == 2) ? 1'b1 : 1'b0;
            @(posedge clk);
            @(negedge clk);
            check("hold ready", {63'd0, ready_o}, 64'd1);
            check("hold stable", result_o, 64'h0000_0001_0000_014D);
        end
        annul_i = 1'b0;
        release_op("hold");

        // Annul in cycle n+10, new start in n+12 must complete in n+46.
        launch(1'b0, 32'd1234, 32'd10);
        repeat (10) begin
            @(posedge clk);
            @(negedge clk);
        end
        annul_i = 1'b1;
        start_i = 1'b0;
        @(posedge clk);
        @(negedge clk);
        annul_i = 1'b0;
        check("annul n+11 ready", {63'd0, ready_o}, 64'd0);
        @(posedge clk);
        @(negedge clk);
        check("annul n+12 ready", {63'd0, ready_o}, 64'd0);
        launch(1'b0, 32'd1000, 32'd7);
        wait_ready(lat);
        check("annul restart latency", 64'(lat), 64'd34);
        check("annul restart result", result_o, 64'h0000_0006_0000_008E);
        release_op("annul");

        // Reset in cycle n+20 of an operation.
        launch(1'b1, 32'hFFFF_FF9C, 32'd9);
        repeat (20) begin
            @(posedge clk);
            @(negedge clk);
        end
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("midop rst ready", {63'd0, ready_o}, 64'd0);
        check("midop rst result", result_o, 64'd0);
        rst     = 1'b0;
        start_i = 1'b0;
        run_check("after rst", 1'b1, 32'hFFFF_FF9C, 32'd9, 64'hFFFF_FFFF_FFFF_FFF5);

        for (int i = 0; i < 40; i++) begin
            s = 1'($urandom_range(0, 1));
            a = $urandom;
            case ($urandom_range(0, 7))
                0:       b = 32'd0;
                1:       b = 32'($urandom_range(1, 15));
                2:       b = 32'hFFFF_FFFF;
                3:       b = 32'h8000_0000 | $urandom;
                default: b = $urandom;
            endcase
            run_check("random", s, a, b, model(s, a, b));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

endmodule
